// File: rtl/ahb_lite_master.sv
// AHB-Lite initiator: turns single/INCR commands plus a write-data stream into pipelined transfers.
// Optional feature macro AHB_MASTER_ERR_ABORT_EN: an ERROR response aborts the rest of the command.
module ahb_lite_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [2:0]        cmd_size,
  input  logic [7:0]        cmd_len,
  input  logic              wdata_valid,
  output logic              wdata_ready,
  input  logic [DATA_W-1:0] wdata,
  output logic              rdata_valid,
  output logic [DATA_W-1:0] rdata,
  output logic              beat_err,
  output logic              done,
  output logic              done_err,
  output logic [ADDR_W-1:0] HADDR,
  output logic [1:0]        HTRANS,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [2:0]        HBURST,
  output logic [3:0]        HPROT,
  output logic [DATA_W-1:0] HWDATA,
  input  logic [DATA_W-1:0] HRDATA,
  input  logic              HREADY,
  input  logic              HRESP
);
  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_BUSY   = 2'b01;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_LAST, S_ERR2} state_t;

  state_t              state_p0, state_nxt;
  logic [ADDR_W-1:0]   haddr_p0;
  logic                hwrite_p0;
  logic [2:0]          hsize_p0;
  logic [2:0]          hburst_p0;
  logic [8:0]          left_p0;
  logic                first_p0;
  logic                nonseq_p0;
  logic                err_p0;
  logic                vld_p1;
  logic                dwrite_p1;
  logic [DATA_W-1:0]   hwdata_p1;
  logic                vld_p2;
  logic                done_p2;
  logic [DATA_W-1:0]   rdata_p2;

  logic                addr_pend, addr_acc, err_first, finish, drop_rd;
  logic [ADDR_W-1:0]   nxt_addr;

  function automatic logic [ADDR_W-1:0] incr_addr(input logic [ADDR_W-1:0] a,
                                                  input logic [2:0] sz);
    incr_addr = a + (ADDR_W'(1) << sz);
  endfunction

  assign nxt_addr  = incr_addr(haddr_p0, hsize_p0);
  assign err_first = vld_p1 && HRESP && !HREADY && (state_p0 != S_ERR2);

`ifdef AHB_MASTER_ERR_ABORT_EN
  assign addr_pend = (state_p0 == S_ADDR) && !err_first;
  assign finish    = ((state_p0 == S_LAST) || (state_p0 == S_ERR2)) && HREADY;
  assign drop_rd   = (state_p0 == S_ERR2);
`else
  // A transfer still waiting for its address phase stays on the bus through both ERROR cycles.
  assign addr_pend = (state_p0 == S_ADDR) || ((state_p0 == S_ERR2) && (left_p0 != 9'd0));
  assign finish    = HREADY && ((state_p0 == S_LAST) ||
                                ((state_p0 == S_ERR2) && (left_p0 == 9'd0)));
  assign drop_rd   = 1'b0;
`endif

  always_comb begin
    state_nxt = state_p0;
    HTRANS    = TR_IDLE;
    if (addr_pend) begin
      if (hwrite_p0 && !wdata_valid) HTRANS = first_p0 ? TR_IDLE : TR_BUSY;
      else                           HTRANS = nonseq_p0 ? TR_NONSEQ : TR_SEQ;
    end
    addr_acc    = HTRANS[1] && HREADY;
    wdata_ready = addr_acc && hwrite_p0;
    case (state_p0)
      S_IDLE: if (cmd_valid) state_nxt = S_ADDR;
      S_ADDR: begin
        if (err_first)                         state_nxt = S_ERR2;
        else if (addr_acc && left_p0 == 9'd1)  state_nxt = S_LAST;
      end
      S_LAST: begin
        if (err_first)   state_nxt = S_ERR2;
        else if (HREADY) state_nxt = S_IDLE;
      end
      S_ERR2: begin
        if (HREADY) begin
          if (finish)                           state_nxt = S_IDLE;
          else if (addr_acc && left_p0 == 9'd1) state_nxt = S_LAST;
          else                                  state_nxt = S_ADDR;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // p0: address phase / command state, p1: data phase, p2: completion pulses
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_p0  <= S_IDLE;
      haddr_p0  <= '0;
      hwrite_p0 <= 1'b0;
      hsize_p0  <= 3'd0;
      hburst_p0 <= 3'd0;
      left_p0   <= 9'd0;
      first_p0  <= 1'b0;
      nonseq_p0 <= 1'b0;
      err_p0    <= 1'b0;
      vld_p1    <= 1'b0;
      dwrite_p1 <= 1'b0;
      hwdata_p1 <= '0;
      vld_p2    <= 1'b0;
      done_p2   <= 1'b0;
    end else begin
      state_p0 <= state_nxt;
      done_p2  <= finish;
      vld_p2   <= vld_p1 && HREADY && !dwrite_p1 && !drop_rd;
      if (state_p0 == S_IDLE && cmd_valid) begin
        haddr_p0  <= cmd_addr;
        hwrite_p0 <= cmd_write;
        hsize_p0  <= cmd_size;
        hburst_p0 <= (cmd_len == 8'd0) ? 3'b000 : 3'b001;
        left_p0   <= {1'b0, cmd_len} + 9'd1;
        first_p0  <= 1'b1;
        nonseq_p0 <= 1'b1;
        err_p0    <= 1'b0;
      end
      if (addr_acc) begin
        haddr_p0  <= nxt_addr;
        left_p0   <= left_p0 - 9'd1;
        first_p0  <= 1'b0;
        nonseq_p0 <= (nxt_addr[9:0] == 10'd0);
        dwrite_p1 <= hwrite_p0;
      end
      if (addr_acc)    vld_p1 <= 1'b1;
      else if (HREADY) vld_p1 <= 1'b0;
      if (wdata_ready) hwdata_p1 <= wdata;
      if (err_first)   err_p0 <= 1'b1;
    end
  end

  always_ff @(posedge HCLK) begin
    if (vld_p1 && HREADY) rdata_p2 <= HRDATA;
  end

  assign cmd_ready   = (state_p0 == S_IDLE);
  assign beat_err    = (state_p0 == S_ERR2) && HREADY;
  assign done        = done_p2;
  assign done_err    = done_p2 && err_p0;
  assign rdata_valid = vld_p2;
  assign rdata       = rdata_p2;
  assign HADDR       = haddr_p0;
  assign HWRITE      = hwrite_p0;
  assign HSIZE       = hsize_p0;
  assign HBURST      = hburst_p0;
  assign HPROT       = 4'b0011;
  assign HWDATA      = hwdata_p1;
endmodule

// File: tb/tb_ahb_lite_master.sv
// Directed bench for ahb_lite_master: a bench-side AHB slave plus a transfer-level model
// checked every cycle, and literal expectations for each test-plan scenario.
`timescale 1ns/1ps
module tb_ahb_lite_master;
`ifdef AHB_MASTER_ERR_ABORT_EN
  localparam bit ABORT = 1'b1;
`else
  localparam bit ABORT = 1'b0;
`endif

  logic        HCLK, HRESET;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr;
  logic [2:0]  cmd_size;
  logic [7:0]  cmd_len;
  logic        wdata_valid, wdata_ready;
  logic [31:0] wdata, rdata;
  logic        rdata_valid, beat_err, done, done_err;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS;
  logic        HWRITE, HREADY, HRESP;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;

  ahb_lite_master #(.ADDR_W(32), .DATA_W(32)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_len(cmd_len),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .rdata_valid(rdata_valid), .rdata(rdata), .beat_err(beat_err),
    .done(done), .done_err(done_err),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBURST(HBURST), .HPROT(HPROT), .HWDATA(HWDATA),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // command being exercised and its slave/stimulus profile
  bit          cur_write;
  logic [31:0] cur_addr;
  logic [2:0]  cur_size;
  int          cur_len;
  int          waits[0:256];
  int          gaps[0:256];
  logic [31:0] words[0:256];
  int          err_beat;
  int          exp_phases, exp_busy;

  // model / slave state
  bit          in_cmd, dp_act, dp_write, err_ph, done_due, rv_due, err_seen, done_err_last;
  int          dp_beat, dp_wait, acc_cnt, comp_cnt, busy_cnt, beat_err_cnt, done_cnt;
  int          wk, gap_left, cyc, acc_cyc, first_addr_cyc, last_comp_cyc, done_cyc;
  logic [31:0] rv_val;
  bit          prev_hready;
  logic [1:0]  prev_trans;
  logic [31:0] prev_addr;
  logic [31:0] addr_log[0:15];
  logic [1:0]  trans_log[0:15];
  logic [2:0]  burst_first;
  logic [31:0] rd_log[0:15];
  logic [31:0] wr_log[0:15];
  int          rd_cnt, wr_cnt;

  always @(negedge HCLK) begin
    if (!dp_act)              begin HREADY = 1'b1;   HRESP = 1'b0; end
    else if (dp_wait > 0)     begin HREADY = 1'b0;   HRESP = 1'b0; end
    else if (dp_beat == err_beat) begin HREADY = err_ph; HRESP = 1'b1; end
    else                      begin HREADY = 1'b1;   HRESP = 1'b0; end
    HRDATA = dp_act ? 32'(dp_beat + 1) : 32'h0;
    wdata_valid = cur_write && (in_cmd || cmd_valid) && (wk <= cur_len) && (gap_left == 0);
    wdata = (wk >= 0 && wk <= 256) ? words[wk] : 32'h0;
    #3;
    if (HRESET) begin
      in_cmd = 0; dp_act = 0; err_ph = 0; done_due = 0; rv_due = 0;
      wk = 9999; gap_left = 0; prev_hready = 1; prev_trans = 2'b00; prev_addr = 0;
    end else begin
      logic [31:0] ea;
      cyc++;
      check("hprot", HPROT, 4'b0011);
      check("cmd_ready", cmd_ready, !in_cmd);
      check("done", done, done_due);
      check("rdata_valid", rdata_valid, rv_due);
      if (rv_due) check("rdata", rdata, rv_val);
      check("beat_err", beat_err, dp_act && HREADY && HRESP);
      check("wdata_ready", wdata_ready, in_cmd && HTRANS[1] && HREADY && HWRITE);
      if (!in_cmd) check("idle_trans", HTRANS, 2'b00);
`ifdef AHB_MASTER_ERR_ABORT_EN
      if (HRESP) check("err_cancel_idle", HTRANS, 2'b00);
`endif
      if (!prev_hready && prev_trans[1]) begin
        check("hold_addr", HADDR, prev_addr);
        check("hold_trans", HTRANS, prev_trans);
      end
      if (HTRANS != 2'b00) begin
        check("hwrite", HWRITE, cur_write);
        check("hsize", HSIZE, cur_size);
        check("hburst", HBURST, (cur_len == 0) ? 3'b000 : 3'b001);
      end
      if (HTRANS == 2'b01) busy_cnt++;
      if (done) begin
        done_cnt++; done_cyc = cyc; done_err_last = done_err;
        check("done_err", done_err, err_seen);
      end
      if (beat_err) beat_err_cnt++;
      if (rdata_valid && rd_cnt < 16) begin rd_log[rd_cnt] = rdata; rd_cnt++; end
      done_due = 0; rv_due = 0;
      if (dp_act) begin
        if (HREADY) begin
          comp_cnt++; last_comp_cyc = cyc;
          if (dp_write) begin
            check("hwdata", HWDATA, words[dp_beat]);
            if (wr_cnt < 16) begin wr_log[wr_cnt] = HWDATA; wr_cnt++; end
          end else if (!(ABORT && HRESP)) begin
            rv_due = 1; rv_val = 32'(dp_beat + 1);
          end
          if (HRESP) err_seen = 1;
          if (comp_cnt == exp_phases) begin in_cmd = 0; done_due = 1; end
          dp_act = 0; err_ph = 0;
        end else if (dp_wait > 0) dp_wait--;
        else if (dp_beat == err_beat) err_ph = 1;
      end
      if (in_cmd && HTRANS[1] && HREADY) begin
        ea = cur_addr + (32'(acc_cnt) << cur_size);
        check("haddr", HADDR, ea);
        check("htrans", HTRANS, (acc_cnt == 0 || ea[9:0] == 10'd0) ? 2'b10 : 2'b11);
        if (acc_cnt == 0) begin
          check("first_nonseq_latency", cyc, acc_cyc + 1);
          first_addr_cyc = cyc; burst_first = HBURST;
        end
        if (acc_cnt < 16) begin addr_log[acc_cnt] = HADDR; trans_log[acc_cnt] = HTRANS; end
        dp_act = 1; dp_beat = acc_cnt; dp_write = HWRITE; dp_wait = waits[acc_cnt];
        acc_cnt++;
      end
      if (wdata_ready) begin
        wk++; gap_left = (wk <= 256) ? gaps[wk] : 0;
      end else if (!wdata_valid && gap_left > 0 && in_cmd) gap_left--;
      if (cmd_valid && cmd_ready) begin
        in_cmd = 1; acc_cyc = cyc; acc_cnt = 0; comp_cnt = 0; busy_cnt = 0;
        err_seen = 0; beat_err_cnt = 0; rd_cnt = 0; wr_cnt = 0;
      end
      prev_hready = HREADY; prev_trans = HTRANS; prev_addr = HADDR;
    end
  end

  task automatic clear_cfg();
    for (int i = 0; i <= 256; i++) begin
      waits[i] = 0; gaps[i] = 0; words[i] = 32'hA500_0000 + 32'(i);
    end
    err_beat = -1;
  endtask

  int done_before;

  // called at posedge+1; the command is accepted on the following rising edge
  task automatic issue(input bit w, input logic [31:0] a, input logic [2:0] s, input int len);
    cur_write = w; cur_addr = a; cur_size = s; cur_len = len;
    exp_phases = (ABORT && err_beat >= 0 && err_beat <= len) ? err_beat + 1 : len + 1;
    exp_busy = 0;
    for (int i = 1; i <= len; i++) exp_busy += gaps[i];
    wk = 0; gap_left = gaps[0]; done_before = done_cnt;
    cmd_write = w; cmd_addr = a; cmd_size = s; cmd_len = 8'(len);
    cmd_valid = 1'b1;
    @(posedge HCLK); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic finish_cmd();
    for (int i = 0; i < 400 && done_cnt == done_before; i++) begin
      @(posedge HCLK); #1;
    end
    check("done_seen", done_cnt - done_before, 1);
    check("phases_issued", acc_cnt, exp_phases);
    check("beats_completed", comp_cnt, exp_phases);
    check("busy_cycles", busy_cnt, exp_busy);
    repeat (2) @(posedge HCLK);
    #1;
  endtask

  initial begin
    HRESET = 1'b1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_size = 0; cmd_len = 0;
    HREADY = 1; HRESP = 0; HRDATA = 0; wdata_valid = 0; wdata = 0;
    cur_write = 0; cur_addr = 0; cur_size = 0; cur_len = 0; wk = 9999; gap_left = 0;
    done_cnt = 0; cyc = 0; dp_act = 0; in_cmd = 0;
    clear_cfg();
    repeat (3) @(posedge HCLK);
    #1;
    check("rst_htrans", HTRANS, 2'b00);
    check("rst_haddr", HADDR, 32'h0);
    check("rst_ctrl", {HWRITE, HSIZE, HBURST, HPROT}, {1'b0, 3'd0, 3'd0, 4'b0011});
    check("rst_hwdata", HWDATA, 32'h0);
    check("rst_cmd_ready", cmd_ready, 1'b1);
    check("rst_pulses", {rdata_valid, beat_err, done, done_err}, 4'b0000);
    HRESET = 1'b0;
    @(posedge HCLK); #1;

    // single write
    clear_cfg(); words[0] = 32'hDEADBEEF;
    issue(1, 32'h100, 3'd2, 0);
    finish_cmd();
    check("t1_addr", addr_log[0], 32'h100);
    check("t1_trans", trans_log[0], 2'b10);
    check("t1_burst", burst_first, 3'b000);
    check("t1_wdata", wr_log[0], 32'hDEADBEEF);
    check("t1_data_lat", last_comp_cyc - first_addr_cyc, 1);
    check("t1_done_lat", done_cyc - last_comp_cyc, 1);

    // INCR read with two wait states on beat 2
    clear_cfg(); waits[1] = 2;
    issue(0, 32'h40, 3'd2, 3);
    finish_cmd();
    for (int i = 0; i < 4; i++) begin
      logic [31:0] ea_l[4];
      ea_l = '{32'h40, 32'h44, 32'h48, 32'h4C};
      check("t2_addr", addr_log[i], ea_l[i]);
      check("t2_trans", trans_log[i], (i == 0) ? 2'b10 : 2'b11);
      check("t2_rdata", rd_log[i], 32'(i + 1));
    end
    check("t2_rd_cnt", rd_cnt, 4);
    check("t2_span", last_comp_cyc - first_addr_cyc, 6);

    // INCR write with late data before beat 2
    clear_cfg(); gaps[1] = 3;
    words[0] = 32'h1111_0001; words[1] = 32'h2222_0002; words[2] = 32'h3333_0003;
    issue(1, 32'h80, 3'd2, 2);
    finish_cmd();
    check("t3_busy", busy_cnt, 3);
    check("t3_addr1", addr_log[1], 32'h84);
    check("t3_w0", wr_log[0], 32'h1111_0001);
    check("t3_w1", wr_log[1], 32'h2222_0002);
    check("t3_w2", wr_log[2], 32'h3333_0003);

    // 1 KB boundary restart
    clear_cfg();
    issue(0, 32'h3F8, 3'd2, 3);
    finish_cmd();
    check("t4_a0", {addr_log[0], trans_log[0]}, {32'h3F8, 2'b10});
    check("t4_a1", {addr_log[1], trans_log[1]}, {32'h3FC, 2'b11});
    check("t4_a2", {addr_log[2], trans_log[2]}, {32'h400, 2'b10});
    check("t4_a3", {addr_log[3], trans_log[3]}, {32'h404, 2'b11});
    check("t4_span", last_comp_cyc - first_addr_cyc, 4);

    // ERROR on beat 2 of a 4-beat read
    clear_cfg(); err_beat = 1;
    issue(0, 32'h500, 3'd2, 3);
    finish_cmd();
    check("t5_beat_err_cnt", beat_err_cnt, 1);
    check("t5_done_err", done_err_last, 1'b1);
`ifdef AHB_MASTER_ERR_ABORT_EN
    check("t5_rd_cnt", rd_cnt, 1);
    check("t5_rd0", rd_log[0], 32'h1);
    check("t5_phases", acc_cnt, 2);
`else
    check("t5_rd_cnt", rd_cnt, 4);
    check("t5_rd3", rd_log[3], 32'h4);
    check("t5_phases", acc_cnt, 4);
`endif

    // reset in the middle of an 8-beat write, then a clean command
    clear_cfg();
    issue(1, 32'h600, 3'd2, 7);
    for (int i = 0; i < 50 && acc_cnt < 3; i++) begin
      @(posedge HCLK); #1;
    end
    check("t6_reached_beat3", acc_cnt >= 3, 1'b1);
    HRESET = 1'b1;
    #1;
    check("t6_rst_htrans", HTRANS, 2'b00);
    check("t6_rst_ready", cmd_ready, 1'b1);
    @(posedge HCLK); #1;
    HRESET = 1'b0;
    repeat (3) @(posedge HCLK);
    #1;
    check("t6_no_done", done_cnt, done_before);
    clear_cfg();
    issue(0, 32'h700, 3'd2, 0);
    finish_cmd();
    check("t6_new_addr", addr_log[0], 32'h700);
    check("t6_new_trans", trans_log[0], 2'b10);
    check("t6_new_rdata", rd_log[0], 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ahb_lite_master.md
# ahb_lite_master

Synthesizable AHB-Lite master (initiator) that converts a simple command/data-stream interface into pipelined AHB-Lite transfers. It drives the same bus the existing AHB slave agent responds on, acting as the initiator end of the protocol. It supports single transfers and undefined-length INCR bursts, wait states, BUSY insertion when write data is late, 1 KB boundary restarts and two-cycle ERROR responses.

## Interface
- ADDR_W, 32, HADDR and cmd_addr width
- DATA_W, 32, HWDATA/HRDATA width; 32 or 64
- HCLK  in  1  bus clock; all logic rising-edge
- HRESET  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  high only in IDLE state; command accepted when cmd_valid && cmd_ready
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  start address; must be aligned to cmd_size
- cmd_size  in  3  HSIZE encoding; must not exceed log2(DATA_W/8)
- cmd_len  in  8  beats minus 1 (0 = SINGLE)
- wdata_valid / wdata_ready  in / out  1 / 1  write-data handshake, one word per beat
- wdata  in  DATA_W  write data
- rdata_valid  out  1  one-cycle pulse per completed read beat
- rdata  out  DATA_W  read data, valid with rdata_valid
- beat_err  out  1  pulse: completed beat received ERROR
- done  out  1  one-cycle pulse at command completion
- done_err  out  1  valid with done; 1 if any beat erred
- HADDR, HTRANS[1:0], HWRITE, HSIZE[2:0], HBURST[2:0], HPROT[3:0], HWDATA  out  AHB-Lite address/control/data
- HRDATA, HREADY, HRESP  in  AHB-Lite slave response

## Operation
- States: IDLE, ADDR (address phase pending), LAST (data phase of final beat only), ERR2 (second ERROR cycle).
- IDLE: HTRANS=IDLE, cmd_ready=1. On accept: latch the command and go to ADDR. The first beat is NONSEQ. HBURST=SINGLE if cmd_len==0, otherwise INCR. HPROT=4'b0011, constant.
- Write beat address phase is issued only when wdata_valid=1. Otherwise drive IDLE (first beat) or BUSY (later beats), with HADDR/control held.
- wdata_ready is high in the cycle the write address phase is accepted (HREADY=1, HTRANS NONSEQ/SEQ). wdata is registered into HWDATA for the following data phase and held until HREADY=1.
- After each accepted beat: HADDR += 1<<HSIZE, beats remaining decrements. The next beat is SEQ, or NONSEQ if the new address is a multiple of 1024.
- After the last address phase is accepted, drive HTRANS=IDLE and go to LAST. On HREADY=1, pulse done and return to IDLE.
- Read beat completion: HREADY=1 in its data phase. rdata is registered from HRDATA and rdata_valid is pulsed the next cycle.
- ERROR: HRESP=1 with HREADY=0 is the first cycle; go to ERR2. On HREADY=1, the erred beat completes with beat_err=1, and done_err is set sticky for the command.
- cmd_len is 8 bits, so a command is at most 256 beats. The address wraps modulo 2^ADDR_W; no special handling.

## Timing
- Reset values: HTRANS=00, HADDR=0, HWRITE=0, HSIZE=0, HBURST=0, HPROT=0011, HWDATA=0, cmd_ready=1 (IDLE), all pulse outputs 0.
- Reset mid-burst: immediate return to IDLE. Outstanding beats are discarded and no done is issued.
- Address-to-data pipeline: one cycle with zero wait states. With back-to-back beats, N beats occupy N+1 cycles.
- The earliest NONSEQ is the cycle after acceptance, since command fields are registered.
- Read latency from data-phase HREADY=1 to rdata_valid is 1 cycle. done is asserted in the cycle after the last HREADY=1.
- Address/control outputs and HWDATA only change when HREADY=1. The exceptions are the IDLE cancel on ERROR and the transition from BUSY to SEQ.
- A new command cannot be accepted until done. No overlap between commands.

## Configuration
- AHB_MASTER_ERR_ABORT_EN defined:
  - In the first ERROR cycle, drive HTRANS=IDLE and cancel all remaining beats.
  - On the second cycle, pulse beat_err, then done with done_err=1.
  - No further rdata_valid pulses for the command.
- AHB_MASTER_ERR_ABORT_EN undefined:
  - The pending address phase is held through both ERROR cycles.
  - The burst continues to completion, with beat_err flagged per erred beat.

## Test plan
- Single write, addr 0x100, size 2, wdata 0xDEADBEEF, HREADY=1 -> NONSEQ@0x100 with HBURST=SINGLE, HWDATA=0xDEADBEEF the next cycle, done 1 cycle after.
- INCR read, len=3, addr 0x40, HRDATA 1..4, HREADY low 2 cycles on beat 2 -> addresses 0x40/44/48/4C (NONSEQ, SEQ, SEQ, SEQ) held during wait; 4 rdata_valid pulses with 1,2,3,4.
- INCR write, len=2, wdata_valid dropped 3 cycles before beat 2 -> HTRANS=BUSY for 3 cycles at 0x...4, then SEQ; all 3 words written in order.
- INCR read, size 2, from 0x3F8, len=3 -> 0x3F8 NONSEQ, 0x3FC SEQ, 0x400 NONSEQ, 0x404 SEQ.
- ERROR on beat 2 of a len=3 read:
  - With the macro: HTRANS=IDLE in the first error cycle, 1 rdata_valid, done with done_err=1.
  - Without the macro: 4 completions, beat_err on beat 2, done_err=1.
- HRESET asserted during beat 3 of a len=7 write -> HTRANS=00 and cmd_ready=1 immediately; next command starts cleanly with NONSEQ.
